// File: rtl/sdiv_pkg.sv
// sdiv_pkg: state encoding, default width and magnitude helper shared by the signed divider.
package sdiv_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} sdiv_state_e;

    localparam int DW_DEF = 16;
    localparam int MAG_W  = 64;

    // Callers sign-extend to MAG_W and keep the low DW bits, so the most-negative value maps cleanly.
    function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] v);
        return v[MAG_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/sdiv_step.sv
// sdiv_step: one restoring shift-subtract iteration, producing a single quotient bit.
module sdiv_step #(
    parameter int DW = 16
) (
    input  logic [DW:0]   rem_i,
    input  logic [DW-1:0] q_i,
    input  logic [DW-1:0] dvs_i,
    output logic [DW:0]   rem_o,
    output logic [DW-1:0] q_o
);
    logic [DW+1:0] rem_sh;
    logic [DW:0]   trial;
    logic          ge;

    // The compare uses the full shifted width; the subtraction result always fits DW+1 bits when kept.
    always_comb begin
        rem_sh = {rem_i, q_i[DW-1]};
        ge     = (rem_sh >= {2'b00, dvs_i});
        trial  = rem_sh[DW:0] - {1'b0, dvs_i};
        rem_o  = ge ? trial : rem_sh[DW:0];
        q_o    = {q_i[DW-2:0], ge};
    end

endmodule

// File: rtl/sdiv_seq_ctrl.sv
// sdiv_seq_ctrl: start/done sequencer for a signed restoring divider, one quotient bit per cycle.
// Build option SDIV_RESIDUE_SIGN_EN gives the residue the dividend's sign (C truncated division).
module sdiv_seq_ctrl
    import sdiv_pkg::*;
#(
    parameter int  DW    = DW_DEF,
    localparam int CNT_W = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] residue,
    output logic          div_by_zero,
    output logic          overflow
);
    localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

    sdiv_state_e      state_q, state_d;
    logic [DW-1:0]    opa_q, opa_d, opb_q, opb_d, dmag_q, dmag_d, q_q, q_d;
    logic [DW-1:0]    quot_q, quot_d, res_q, res_d;
    logic [DW:0]      rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [DW-1:0]    dvd_abs, dvs_abs, rem_lo, res_fix, res_dbz, step_q;
    logic [DW:0]      step_rem;

    assign dvd_abs = DW'(abs_mag({{(MAG_W-DW){opa_q[DW-1]}}, opa_q}));
    assign dvs_abs = DW'(abs_mag({{(MAG_W-DW){opb_q[DW-1]}}, opb_q}));
    assign rem_lo  = rem_q[DW-1:0];

`ifdef SDIV_RESIDUE_SIGN_EN
    assign res_fix = dvd_neg_q ? -rem_lo : rem_lo;
    assign res_dbz = opa_q;
`else
    assign res_fix = rem_lo;
    assign res_dbz = dvd_abs;
`endif

    sdiv_step #(.DW(DW)) u_step (
        .rem_i (rem_q),
        .q_i   (q_q),
        .dvs_i (dmag_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        dmag_d    = dmag_q;
        q_d       = q_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        quot_d    = quot_q;
        res_d     = res_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                opa_d   = dividend;
                opb_d   = divisor;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = LOAD;
            end
            LOAD: begin
                dvd_neg_d = opa_q[DW-1];
                dvs_neg_d = opb_q[DW-1];
                q_d       = dvd_abs;
                dmag_d    = dvs_abs;
                rem_d     = '0;
                cnt_d     = CNT_W'(DW);
                if (opb_q == '0) begin
                    quot_d  = '1;
                    res_d   = res_dbz;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d = step_rem;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                // Only most-negative / -1 yields a same-sign magnitude of 2^(DW-1); report it raw.
                if (q_q == Q_MIN && dvd_neg_q == dvs_neg_q) begin
                    quot_d = q_q;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = (dvd_neg_q ^ dvs_neg_q) ? -q_q : q_q;
                end
                res_d   = res_fix;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            dmag_q    <= '0;
            q_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quot_q    <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            dmag_q    <= dmag_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            quot_q    <= quot_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign residue     = res_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_sdiv_seq_ctrl.sv
// Scoreboard bench for sdiv_seq_ctrl: directed and random divides against an integer-arithmetic model.
module tb_sdiv_seq_ctrl;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          busy, done, div_by_zero, overflow;
    logic [DW-1:0] quotient, residue;

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    sdiv_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .residue     (residue),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: C-style truncating division on plain integers; k is the acceptance edge count.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input int k);
        exp_t e;
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.cyc = k + DW + 2;
        if (bi == 0) begin
            e.dbz = 1'b1;
            e.q   = '1;
            e.cyc = k + 1;
`ifdef SDIV_RESIDUE_SIGN_EN
            e.r = a;
`else
            e.r = 16'(ai < 0 ? -ai : ai);
`endif
        end else if (ai == -32768 && bi == -1) begin
            e.ovf = 1'b1;
            e.q   = 16'h8000;
            e.r   = '0;
        end else begin
            qi  = ai / bi;
            ri  = ai % bi;
            e.q = 16'(qi);
`ifdef SDIV_RESIDUE_SIGN_EN
            e.r = 16'(ri);
`else
            e.r = 16'(ri < 0 ? -ri : ri);
`endif
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient",    32'(quotient),    32'(e.q));
                check("residue",     32'(residue),     32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("overflow",    32'(overflow),    32'(e.ovf));
                check("done_cycle",  32'(cyc),         32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit push);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        if (push) sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 40) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b);
        issue(a, b, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, b;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_residue", 32'(residue), 32'd0);
        check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run(16'd100, 16'd7);
        run(-16'sd100, 16'd7);
        run(16'h8000, 16'hFFFF);
        run(16'h8000, 16'd1);
        run(16'd1234, 16'd0);
        run(16'd0, 16'd5);
        run(16'd7, 16'd100);
        run(16'd32767, 16'h8000);
        run(16'h8000, 16'h8000);
        run(16'h8000, 16'd0);

        // A start pulse during ITER must not disturb the operation in flight.
        issue(16'd100, 16'd7, 1'b1);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = -16'sd999;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Leave nonzero results and flags behind, then abort a divide with reset.
        run(16'd1234, 16'd0);
        issue(16'd30000, 16'd3, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_residue", 32'(residue), 32'd0);
        check("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run(16'd50, -16'sd5);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 16'd0;
                1:       b = 16'hFFFF;
                2, 3:    b = 16'($urandom_range(1, 20));
                4:       b = -16'($urandom_range(1, 20));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            run(a, b);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
